// File: rtl/monitor_temperatura.sv
// monitor_temperatura: multi-channel temperature supervisor with
// persistence-qualified, hysteretic hot/cold alarms per channel.
module monitor_temperatura #(
    parameter int unsigned W        = 6,
    parameter int unsigned N        = 4,
    parameter int unsigned PERSIST  = 3,
    parameter int unsigned REF_HOT  = 28,
    parameter int unsigned REF_COLD = 17,
    parameter int unsigned HYST     = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           sample_valid,
    input  logic [N*W-1:0] tpValor,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_sel,
    input  logic [W-1:0]   cfg_data,
    input  logic [N-1:0]   alarm_ack,
    output logic [N-1:0]   alarmaVisualC,
    output logic [N-1:0]   alarmaVisualF,
    output logic [N-1:0]   alarm_latched,
    output logic           tOut
);

    localparam int CW = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        HOT    = 2'd1,
        COLD   = 2'd2
    } chState_t;

    logic [W-1:0]  refHot;
    logic [W-1:0]  refCold;
    logic [W-1:0]  hyst;
    logic [W:0]    hotDiff;
    logic [W:0]    coldSum;
    logic [W-1:0]  hotExit;
    logic [W-1:0]  coldExit;

    logic [W-1:0]  smp     [N];
    logic [N-1:0]  qHot;
    logic [N-1:0]  qCold;
    logic [CW:0]   runLen  [N];

    chState_t      state    [N];
    chState_t      stateNxt [N];
    logic [CW-1:0] cnt      [N];
    logic [CW-1:0] cntNxt   [N];
    logic [N-1:0]  dir;
    logic [N-1:0]  dirNxt;
    logic [N-1:0]  enter;

    // Threshold registers; a write is visible from the next cycle on
    always_ff @(posedge clk) begin
        if (reset) begin
            refHot  <= W'(REF_HOT);
            refCold <= W'(REF_COLD);
            hyst    <= W'(HYST);
        end else if (cfg_we) begin
            case (cfg_sel)
                2'd0:    refHot  <= cfg_data;
                2'd1:    refCold <= cfg_data;
                2'd2:    hyst    <= cfg_data;
                default: ;
            endcase
        end
    end

    // Exit thresholds at W+1 bits, clamped back into range
    always_comb begin
        hotDiff  = {1'b0, refHot} - {1'b0, hyst};
        coldSum  = {1'b0, refCold} + {1'b0, hyst};
        hotExit  = hotDiff[W] ? '0 : hotDiff[W-1:0];
        coldExit = coldSum[W] ? '1 : coldSum[W-1:0];
    end

    // Split samples and qualify them against the entry thresholds
    always_comb begin
        for (int i = 0; i < N; i++) begin
            smp[i]   = tpValor[i*W +: W];
            qHot[i]  = smp[i] > refHot;
            qCold[i] = smp[i] < refCold;
        end
    end

    // Per-channel next state: persistence count in NORMAL, hysteresis exit
    always_comb begin
        for (int i = 0; i < N; i++) begin
            stateNxt[i] = state[i];
            cntNxt[i]   = cnt[i];
            dirNxt[i]   = dir[i];
            enter[i]    = 1'b0;
            runLen[i]   = '0;
            if (sample_valid) begin
                unique case (state[i])
                    NORMAL: begin
                        if (qHot[i] || qCold[i]) begin
                            if (cnt[i] != '0 && dir[i] == qHot[i])
                                runLen[i] = {1'b0, cnt[i]} + 1'b1;
                            else
                                runLen[i] = (CW+1)'(1);
                            dirNxt[i] = qHot[i];
                            if (runLen[i] == (CW+1)'(PERSIST)) begin
                                stateNxt[i] = qHot[i] ? HOT : COLD;
                                cntNxt[i]   = '0;
                                enter[i]    = 1'b1;
                            end else begin
                                cntNxt[i] = runLen[i][CW-1:0];
                            end
                        end else begin
                            cntNxt[i] = '0;
                        end
                    end
                    HOT: begin
                        if (smp[i] <= hotExit) begin
                            stateNxt[i] = NORMAL;
                            cntNxt[i]   = '0;
                        end
                    end
                    COLD: begin
                        if (smp[i] >= coldExit) begin
                            stateNxt[i] = NORMAL;
                            cntNxt[i]   = '0;
                        end
                    end
                    default: begin
                        stateNxt[i] = NORMAL;
                        cntNxt[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Channel state registers and registered visual alarms
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= NORMAL;
                cnt[i]   <= '0;
            end
            dir           <= '1;
            alarmaVisualC <= '0;
            alarmaVisualF <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state[i]         <= stateNxt[i];
                cnt[i]           <= cntNxt[i];
                alarmaVisualC[i] <= (stateNxt[i] == HOT);
                alarmaVisualF[i] <= (stateNxt[i] == COLD);
            end
            dir <= dirNxt;
        end
    end

    // Sticky alarm flags (entry beats ack) and delayed global summary
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_latched <= '0;
            tOut          <= 1'b0;
        end else begin
            alarm_latched <= enter | (alarm_latched & ~alarm_ack);
            tOut          <= |(alarmaVisualC | alarmaVisualF);
        end
    end

endmodule
